quant_scheduler: RTL
====================

Name: quant_scheduler

Overview:
- Shares one 8x8 quantizer pipeline between NUM_REQ DCT block producers: channel 0 = Y, 1 = Cb, 2 = Cr.
- Each cycle, at most one requester is granted using round-robin arbitration.
- The granted block is registered onto the quantizer input together with a channel tag that selects the quantization table.
- Issued tags are tracked through the fixed quantizer latency so that each completed block leaves with its channel ID.
- Issue is gated by downstream credits, because the quantizer pipeline cannot stall.

Parameters:
- NUM_REQ, 3: number of requesting channels (2..4).
- CREDITS, 4: downstream buffer slots, i.e. the maximum number of blocks in flight or unconsumed.
- TAG_DEPTH, 8: depth of the in-flight tag FIFO. Must satisfy TAG_DEPTH >= CREDITS; checked at elaboration, fatal if violated.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-channel block available.
- req_ready  out  NUM_REQ  per-channel grant; a transfer occurs when req_valid[i] & req_ready[i].
- z_in  in  NUM_REQ x 8x8 x 11 signed  per-channel DCT coefficient blocks.
- q_z  out  8x8 x 11 signed  block driven to the quantizer Z input.
- q_enable  out  1  one-cycle pulse to the quantizer enable.
- q_chan  out  2  table select for the issued block.
- q_out_enable  in  1  quantizer completion pulse.
- out_valid  out  1  one-cycle pulse: quantized block for out_chan is complete.
- out_chan  out  2  channel ID of the completed block.
- credit_return  in  1  one-cycle pulse: the downstream consumer freed one slot.
- credits  out  clog2(CREDITS+1)  current credit count.
- busy  out  1  high when the tag FIFO is non-empty or q_enable is high.
- err  out  1  sticky protocol-error flag.

Behaviour:
- Reset values (asynchronous, immediate on rst):
  - q_z = 0, q_enable = 0, q_chan = 0.
  - out_valid = 0, out_chan = 0.
  - credits = CREDITS, err = 0, busy = 0.
  - round-robin pointer = 0, tag FIFO empty.
- Grant (combinational):
  - Grant is allowed only when credits > 0.
  - Among asserted req_valid, the first channel at or after the pointer, searching upward with wrap, is granted.
  - req_ready is one-hot or zero. req_ready may depend on req_valid; producers must not make req_valid depend on req_ready.
- Issue (registered):
  - On a handshake, the next edge loads q_z <= z_in[g], q_chan <= g, q_enable <= 1, and pushes g into the tag FIFO.
  - Credits are decremented on the same edge.
  - The pointer moves to (g+1) mod NUM_REQ.
  - With no handshake, q_enable = 0; q_z and q_chan hold their values.
- Throughput: at most one issue per cycle. Back-to-back issues are legal.
- Completion:
  - On q_out_enable, the FIFO head is popped.
  - Next edge: out_valid = 1 and out_chan = popped tag.
  - Latency from handshake edge to out_valid = 1 (issue) + 4 (quantizer) + 1 = 6 cycles.
  - Completions are strictly in issue order.
- Credits:
  - Issue and credit_return in the same cycle leave credits unchanged.
  - If credit_return arrives while credits == CREDITS, credits saturate and err is set.
- Errors:
  - q_out_enable with an empty tag FIFO: no out_valid pulse, err is set.
  - err clears only on rst.
- Push and pop in the same cycle are legal at any occupancy, including empty (push then pop is not bypassed; out_valid for that tag follows its own completion).
- Reset mid-operation: all in-flight tags are discarded and credits restore to CREDITS. Any quantizer completions after reset count as empty-FIFO errors; the integrator must reset the quantizer together with this block.

Optional Feature:
- Macro: QSCHED_STRICT_PRIO_EN.
- Defined: fixed priority, lowest index wins (Y over Cb over Cr). The pointer is unused and held at 0.
- Undefined: round-robin as specified above.

Test Plan:
- Single request: Y req_valid=1 for 1 cycle, z_in[0] all = 5, with credits=4 → req_ready[0]=1 that cycle; q_enable pulse next cycle with q_z = 5 and q_chan = 0; credits=3; out_valid with out_chan=0 exactly 6 cycles after the handshake.
- Round-robin fairness: all three req_valid held high for 6 cycles with credit_return pulsed every cycle → grant order 0,1,2,0,1,2; credits stay at 4 throughout.
- Credit exhaustion: all requests held valid, no credit_return → exactly 4 issues, then req_ready = 0; a single credit_return pulse → exactly one further issue, to the next channel in round-robin order.
- Simultaneous events: issue and credit_return in the same cycle → credits unchanged; credit_return at credits=4 → credits stay 4 and err=1.
- Error and reset: q_out_enable pulsed with the FIFO empty → no out_valid, err=1. Reset asserted with 3 blocks in flight → outputs go to reset values immediately; credits=4, err=0 after release.
- With QSCHED_STRICT_PRIO_EN defined: Y and Cr held valid → Y is granted every cycle until Y deasserts or credits reach 0.

Source files
------------

// File: rtl/quant_scheduler.sv
// Round-robin, credit-gated issue of DCT blocks to a shared 8x8 quantizer, with
// in-flight channel tags tracked to completion. QSCHED_STRICT_PRIO_EN selects fixed priority.
module quant_scheduler #(
    parameter int NUM_REQ   = 3,
    parameter int CREDITS   = 4,
    parameter int TAG_DEPTH = 8
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NUM_REQ-1:0]                  req_valid,
    output logic [NUM_REQ-1:0]                  req_ready,
    input  logic [NUM_REQ-1:0][63:0][10:0]      z_in,
    output logic [63:0][10:0]                   q_z,
    output logic                                q_enable,
    output logic [1:0]                          q_chan,
    input  logic                                q_out_enable,
    output logic                                out_valid,
    output logic [1:0]                          out_chan,
    input  logic                                credit_return,
    output logic [$clog2(CREDITS+1)-1:0]        credits,
    output logic                                busy,
    output logic                                err
);

    localparam int CW = $clog2(CREDITS + 1);
    localparam int AW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
    localparam int NW = $clog2(TAG_DEPTH + 1);
    localparam logic [CW-1:0] CRED_MAX = CW'(CREDITS);

    if (TAG_DEPTH < CREDITS) begin : g_depth_chk
        $fatal(1, "quant_scheduler: TAG_DEPTH must be >= CREDITS");
    end
    if (NUM_REQ < 2 || NUM_REQ > 4) begin : g_req_chk
        $fatal(1, "quant_scheduler: NUM_REQ must be in 2..4");
    end

    logic [1:0]    ptr;
    logic [1:0]    ptr_nxt;
    logic [1:0]    gnt_idx;
    logic [1:0]    idx;
    logic [2:0]    sum;
    logic          issue;
    logic          pop;
    logic          pop_err;
    logic [1:0]    tag_mem [TAG_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [NW-1:0] count;

    // First valid requester at or after the pointer, wrapping; only with a free credit.
    always_comb begin
        req_ready = '0;
        gnt_idx   = '0;
        issue     = 1'b0;
        idx       = '0;
        sum       = '0;
        if (credits != '0) begin
            for (int unsigned k = 0; k < NUM_REQ; k++) begin
`ifdef QSCHED_STRICT_PRIO_EN
                idx = 2'(k);
`else
                sum = {1'b0, ptr} + 3'(k);
                idx = (sum >= 3'(NUM_REQ)) ? 2'(sum - 3'(NUM_REQ)) : sum[1:0];
`endif
                if (!issue && req_valid[idx]) begin
                    issue   = 1'b1;
                    gnt_idx = idx;
                end
            end
        end
        if (issue) begin
            req_ready[gnt_idx] = 1'b1;
        end
    end

    always_comb begin
`ifdef QSCHED_STRICT_PRIO_EN
        ptr_nxt = '0;
`else
        ptr_nxt = (gnt_idx == 2'(NUM_REQ - 1)) ? '0 : gnt_idx + 2'd1;
`endif
    end

    assign pop     = q_out_enable && (count != '0);
    assign pop_err = q_out_enable && (count == '0);
    assign busy    = (count != '0) || q_enable;

    always_ff @(posedge clk) begin
        if (issue) begin
            tag_mem[wr_ptr] <= gnt_idx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_z       <= '0;
            q_enable  <= 1'b0;
            q_chan    <= '0;
            out_valid <= 1'b0;
            out_chan  <= '0;
            credits   <= CRED_MAX;
            err       <= 1'b0;
            ptr       <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
        end else begin
            q_enable <= issue;
            if (issue) begin
                q_z    <= z_in[gnt_idx];
                q_chan <= gnt_idx;
                ptr    <= ptr_nxt;
                wr_ptr <= (wr_ptr == AW'(TAG_DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
            end

            case ({issue, credit_return})
                2'b10:   credits <= credits - CW'(1);
                2'b01: begin
                    if (credits == CRED_MAX) begin
                        err <= 1'b1;
                    end else begin
                        credits <= credits + CW'(1);
                    end
                end
                default: credits <= credits;
            endcase

            // A same-cycle push never feeds the pop: an empty FIFO here is an error.
            out_valid <= pop;
            if (pop) begin
                out_chan <= tag_mem[rd_ptr];
                rd_ptr   <= (rd_ptr == AW'(TAG_DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
            end
            if (pop_err) begin
                err <= 1'b1;
            end

            case ({issue, pop})
                2'b10:   count <= count + NW'(1);
                2'b01:   count <= count - NW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule
